// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//
// Purpose:
//   Resolves one conditional or unconditional branch at a time. An
//   unconditional branch (BR) or an invalid op resolves directly. A
//   conditional branch (BMI/BPL/BZ/BNZ) waits for an ALU set-result word and
//   resolves from it, or resolves with an error after TIMEOUT flag-less
//   cycles. The result is held until the consumer takes it.
//
// Parameters:
//   N        datapath width in bits
//   TIMEOUT  maximum number of WAIT_FLAG cycles allowed without flag_valid
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    branch request present
//   req_ready    resolver can accept a request (IDLE and not in reset)
//   req_op       000 BR, 001 BMI, 010 BPL, 011 BZ, 100 BNZ, 101-111 invalid
//   req_pc       PC of the branch
//   req_off      two's complement byte offset
//   flag_valid   flag_word is valid this cycle
//   flag_word    ALU set-result; bit0 is the flag
//   out_valid    resolution available
//   out_ready    consumer accepts the resolution
//   out_taken    branch taken
//   out_target   next PC
//   out_err      abnormal resolution
//
// Configuration macro:
//   BRES_FLAG_CHECK_EN  when defined, a sampled flag_word with any of bits
//                       N-1:1 set raises out_err (taken is still computed).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once out_valid rises, out_taken/out_target/out_err stay stable
// until the edge on which out_ready is 1.
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_pc,
  input  logic [N-1:0] req_off,
  input  logic         flag_valid,
  input  logic [N-1:0] flag_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_taken,
  output logic [N-1:0] out_target,
  output logic         out_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [N-1:0]  PC_STEP = N'(4);

  localparam logic [2:0] OP_BR  = 3'b000;
  localparam logic [2:0] OP_BMI = 3'b001;
  localparam logic [2:0] OP_BPL = 3'b010;
  localparam logic [2:0] OP_BZ  = 3'b011;
  localparam logic [2:0] OP_BNZ = 3'b100;

  // State is kept as a named enum so checkers can bind to state_q directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    op_q,     op_d;
  logic [N-1:0]  pc_q,     pc_d;
  logic [N-1:0]  sum_q,    sum_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          taken_q,  taken_d;
  logic [N-1:0]  target_q, target_d;
  logic          err_q,    err_d;

  logic          accept;
  logic          req_is_cond;
  logic          req_is_invalid;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          flag_taken;
  logic          flag_bad;

  // ---------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------
  assign accept         = req_valid && req_ready;
  assign req_is_cond    = (req_op == OP_BMI) || (req_op == OP_BPL) ||
                          (req_op == OP_BZ)  || (req_op == OP_BNZ);
  assign req_is_invalid = (req_op != OP_BR) && !req_is_cond;
  assign cnt_inc        = cnt_q + CW'(1);
  // A flag arriving on the edge the counter would hit TIMEOUT wins.
  assign timeout_hit    = !flag_valid && (cnt_inc == CNT_MAX);

  always_comb begin
    flag_taken = 1'b0;
    case (op_q)
      OP_BMI:  flag_taken = flag_word[0];
      OP_BPL:  flag_taken = !flag_word[0];
      OP_BZ:   flag_taken = (flag_word == '0);
      OP_BNZ:  flag_taken = (flag_word != '0);
      default: flag_taken = 1'b0;
    endcase
  end

`ifdef BRES_FLAG_CHECK_EN
  assign flag_bad = |flag_word[N-1:1];
`else
  assign flag_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_is_cond ? S_WAIT : S_OUT;
        end
      end
      S_WAIT: begin
        if (flag_valid || timeout_hit) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Result registers are gated so nothing leaks outside OUT.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !rst;
    out_valid  = (state_q == S_OUT);
    out_taken  = (state_q == S_OUT) ? taken_q : 1'b0;
    out_target = (state_q == S_OUT) ? target_q : '0;
    out_err    = (state_q == S_OUT) ? err_q : 1'b0;
  end

  // ---------------------------------------------------------------------
  // Datapath next values: request capture, wait counter, resolution
  // ---------------------------------------------------------------------
  always_comb begin
    op_d     = op_q;
    pc_d     = pc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    taken_d  = taken_q;
    target_d = target_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = req_op;
          pc_d     = req_pc;
          sum_d    = req_pc + req_off;
          cnt_d    = '0;
          taken_d  = (req_op == OP_BR);
          target_d = (req_op == OP_BR) ? (req_pc + req_off) : (req_pc + PC_STEP);
          err_d    = req_is_invalid;
        end
      end
      S_WAIT: begin
        if (flag_valid) begin
          taken_d  = flag_taken;
          target_d = flag_taken ? sum_q : (pc_q + PC_STEP);
          err_d    = flag_bad;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            taken_d  = 1'b0;
            target_d = pc_q + PC_STEP;
            err_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      pc_q     <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      pc_q     <= pc_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//
// Self-checking bench for branch_resolver. Directed cases for the called-out
// scenarios, then randomized transactions. Expected results come from a
// transaction-level model (model_result) and travel through exp_q.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// in the same window, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

  localparam int N       = 32;
  localparam int TIMEOUT = 15;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [N-1:0] req_pc;
  logic [N-1:0] req_off;
  logic         flag_valid;
  logic [N-1:0] flag_word;
  logic         out_valid;
  logic         out_ready;
  logic         out_taken;
  logic [N-1:0] out_target;
  logic         out_err;

  always #5 clk = ~clk;

  branch_resolver #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_pc     (req_pc),
    .req_off    (req_off),
    .flag_valid (flag_valid),
    .flag_word  (flag_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_target (out_target),
    .out_err    (out_err)
  );

  // -------------------------------------------------------------------------
  // Scoreboard: {taken, err, target}
  // -------------------------------------------------------------------------
  logic [N+1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [N-1:0] act,
                          input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: what a branch with this op/pc/off/flag should resolve to.
  function automatic logic [N+1:0] model_result(input logic [2:0] op,
                                                input logic [N-1:0] pc,
                                                input logic [N-1:0] off,
                                                input logic [N-1:0] fw,
                                                input bit timed_out);
    logic         taken;
    logic         err;
    logic [N-1:0] tgt;
    taken = 1'b0;
    err   = 1'b0;
    if (op == 3'd0) begin
      taken = 1'b1;
    end else if (op > 3'd4) begin
      err = 1'b1;
    end else if (timed_out) begin
      err = 1'b1;
    end else begin
      case (op)
        3'd1:    taken = fw[0];
        3'd2:    taken = !fw[0];
        3'd3:    taken = (fw == 0);
        default: taken = (fw != 0);
      endcase
`ifdef BRES_FLAG_CHECK_EN
      if ((fw >> 1) != 0) err = 1'b1;
`endif
    end
    if (taken) tgt = pc + off;
    else       tgt = pc + 4;
    return {taken, err, tgt};
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"},  out_valid,  0);
    check_eq({tag, "_taken"},  out_taken,  0);
    check_eq({tag, "_target"}, out_target, 0);
    check_eq({tag, "_err"},    out_err,    0);
  endtask

  task automatic check_result(input string tag, input logic [N+1:0] exp);
    check_eq({tag, "_valid"},  out_valid,  1);
    check_eq({tag, "_taken"},  out_taken,  exp[N+1]);
    check_eq({tag, "_err"},    out_err,    exp[N]);
    check_eq({tag, "_target"}, out_target, exp[N-1:0]);
  endtask

  // Pulse reset away from the clock edge and check the async clear.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_quiet({tag, "_rst"});
    check_eq({tag, "_rst_ready"}, req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq({tag, "_ready_after_rst"}, req_ready, 1);
  endtask

  // One full transaction. delay = flag-less WAIT edges before the flag edge;
  // delay >= TIMEOUT means no flag is ever sent. hold = cycles out_ready is
  // held low in OUT. abort = reset instead of consuming the result.
  task automatic do_txn(input logic [2:0] op, input logic [N-1:0] pc,
                        input logic [N-1:0] off, input logic [N-1:0] fw,
                        input int delay, input int hold, input bit abort);
    bit           is_cond;
    bit           timed_out;
    int           waits;
    logic [N+1:0] exp;
    is_cond   = (op >= 3'd1) && (op <= 3'd4);
    timed_out = is_cond && (delay >= TIMEOUT);

    check_eq("ready_idle", req_ready, 1);
    check_quiet("idle");

    req_valid  = 1'b1;
    req_op     = op;
    req_pc     = pc;
    req_off    = off;
    flag_valid = 1'($urandom_range(0, 1));  // must be ignored on acceptance
    flag_word  = $urandom;
    exp_q.push_back(model_result(op, pc, off, fw, timed_out));
    step();
    req_valid  = 1'b0;
    req_op     = 3'($urandom);
    req_pc     = $urandom;
    req_off    = $urandom;
    flag_valid = 1'b0;
    check_eq("ready_after_accept", req_ready, 0);

    if (is_cond) begin
      check_quiet("wait");
      waits = timed_out ? TIMEOUT : delay;
      for (int i = 0; i < waits; i++) begin
        flag_valid = 1'b0;
        flag_word  = $urandom;
        step();
        if (!timed_out || i < waits - 1) check_quiet("wait");
      end
      if (!timed_out) begin
        flag_valid = 1'b1;
        flag_word  = fw;
        step();
      end
      flag_valid = 1'b0;
    end

    exp = exp_q.pop_front();
    check_result("out", exp);
    for (int h = 0; h < hold; h++) begin
      out_ready  = 1'b0;
      flag_valid = 1'($urandom_range(0, 1));  // ignored in OUT
      flag_word  = $urandom;
      step();
      check_result("out_hold", exp);
      check_eq("ready_in_out", req_ready, 0);
    end
    flag_valid = 1'b0;

    if (abort) begin
      pulse_reset("abort_out");
      check_quiet("after_abort");
    end else begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_quiet("after_hs");
      check_eq("ready_after_hs", req_ready, 1);
    end
  endtask

  // Reset while waiting for the flag: no resolution may appear afterwards.
  task automatic abort_in_wait();
    check_eq("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_pc    = 32'h0000_0400;
    req_off   = 32'h0000_0010;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("abort_wait");
    end
    pulse_reset("abort_wait");
    flag_valid = 1'b1;  // ignored in IDLE
    flag_word  = 32'h0;
    step();
    flag_valid = 1'b0;
    check_quiet("after_wait_abort");
    step();
    check_quiet("after_wait_abort2");
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [2:0]   op;
    logic [N-1:0] fw;
    int           delay;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_pc     = '0;
    req_off    = '0;
    flag_valid = 1'b0;
    flag_word  = '0;
    out_ready  = 1'b0;

    step();
    step();
    check_quiet("reset");
    check_eq("reset_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_reset", req_ready, 1);
    step();

    // Directed scenarios
    do_txn(3'd0, 32'h0000_0100, 32'h0000_0020, 32'h0, 0, 2, 1'b0);          // BR
    do_txn(3'd3, 32'h0000_0200, 32'hFFFF_FFF0, 32'h0, 2, 0, 1'b0);          // BZ, backward
    do_txn(3'd1, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0, 1, 1, 1'b0);          // BMI, pc+4 wraps
    do_txn(3'd4, 32'h0000_1000, 32'h0000_0008, 32'h1, TIMEOUT, 1, 1'b0);    // BNZ timeout
    do_txn(3'd4, 32'h0000_1000, 32'h0000_0008, 32'h1, TIMEOUT - 1, 0, 1'b0); // flag on last edge
    do_txn(3'd2, 32'h0000_3000, 32'h0000_0100, 32'h3, 0, 0, 1'b0);          // BPL, malformed flag
    do_txn(3'd5, 32'h0000_0050, 32'h0000_0010, 32'h0, 0, 0, 1'b0);          // invalid ops
    do_txn(3'd6, 32'h0000_0060, 32'h0000_0010, 32'h0, 0, 1, 1'b0);
    do_txn(3'd7, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0, 0, 0, 1'b0);
    do_txn(3'd0, 32'h0000_0700, 32'h0000_0004, 32'h0, 0, 5, 1'b1);          // reset in OUT
    abort_in_wait();

    // Randomized transactions
    for (int t = 0; t < 200; t++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       fw = '0;
        1:       fw = 32'h1;
        2:       fw = 32'h2 | 32'($urandom_range(0, 1));
        default: fw = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) delay = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
      else                           delay = $urandom_range(0, 4);
      do_txn(op, $urandom, $urandom, fw, delay, $urandom_range(0, 3),
             ($urandom_range(0, 15) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        flag_valid = 1'($urandom_range(0, 1));  // ignored in IDLE
        flag_word  = $urandom;
        step();
        check_quiet("gap");
      end
      flag_valid = 1'b0;
    end

    check_eq("exp_q_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
